// File: rtl/layernorm_pkg.sv
// Shared LayerNorm datapath constants and the square-root FSM state type.
package layernorm_pkg;

  localparam int DATA_WIDTH = 24;
  localparam int FRAC_BITS  = 20;
  // One result bit is produced per pair of radicand bits.
  localparam int SQRT_ITERS = (DATA_WIDTH + FRAC_BITS) / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

endpackage

// File: rtl/variance_sqrt_unit_step.sv
// One restoring digit-by-digit square-root iteration, purely combinational.
// Brings in the next two radicand bits and decides the next root bit.
module sqrt_iter_step #(
  parameter int ITERS = 22
) (
  input  logic [ITERS+1:0] rem_in,
  input  logic [ITERS-1:0] q_in,
  input  logic [1:0]       bits_in,
  output logic [ITERS+1:0] rem_out,
  output logic [ITERS-1:0] q_out
);

  logic [ITERS+1:0] rem_sh;
  logic [ITERS+1:0] trial;

  // Shift in two radicand bits, subtract (4q+1) when it fits.
  always_comb begin
    rem_sh  = {rem_in[ITERS-1:0], bits_in};
    trial   = {q_in, 2'b01};
    rem_out = rem_sh;
    q_out   = {q_in[ITERS-2:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_out = rem_sh - trial;
      q_out   = {q_in[ITERS-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/variance_sqrt_unit.sv
// Bit-serial square root of the S3.20 variance+epsilon stream.
// Handshake: an input is taken on any clock edge where var_plus_eps_valid_in
// and in_ready are both high; valid while in_ready is low is discarded and
// flagged on drop_err the following cycle. Results appear as a one-cycle
// sqrt_valid_out pulse 23 cycles after acceptance; sqrt_out holds afterwards.
module variance_sqrt_unit
  import layernorm_pkg::*;
#(
  parameter int DATA_WIDTH = layernorm_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = layernorm_pkg::FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] var_plus_eps_in,
  input  logic                  var_plus_eps_valid_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] sqrt_out,
  output logic                  sqrt_valid_out,
  output logic                  neg_err,
  output logic                  drop_err,
  output sqrt_state_e           state_dbg
);

  localparam int RAD_W = DATA_WIDTH + FRAC_BITS;
  localparam int ITERS = RAD_W / 2;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  sqrt_state_e      state;
  logic [RAD_W-1:0] rad;
  logic [ITERS+1:0] rem;
  logic [ITERS-1:0] q;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic [ITERS+1:0] rem_nxt;
  logic [ITERS-1:0] q_nxt;

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  sqrt_iter_step #(
    .ITERS (ITERS)
  ) u_step (
    .rem_in  (rem),
    .q_in    (q),
    .bits_in (rad[RAD_W-1 -: 2]),
    .rem_out (rem_nxt),
    .q_out   (q_nxt)
  );

  // Control FSM plus the radicand, remainder and root shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rad            <= '0;
      rem            <= '0;
      q              <= '0;
      cnt            <= '0;
      neg_q          <= 1'b0;
      sqrt_out       <= '0;
      sqrt_valid_out <= 1'b0;
      neg_err        <= 1'b0;
      drop_err       <= 1'b0;
    end else begin
      sqrt_valid_out <= 1'b0;
      neg_err        <= 1'b0;
      drop_err       <= var_plus_eps_valid_in && (state != IDLE);
      case (state)
        IDLE: begin
          if (var_plus_eps_valid_in) begin
            // A negative variance has no real root; compute sqrt(0) and flag it.
            if (var_plus_eps_in[DATA_WIDTH-1]) begin
              rad   <= '0;
              neg_q <= 1'b1;
            end else begin
              rad   <= {var_plus_eps_in, {FRAC_BITS{1'b0}}};
              neg_q <= 1'b0;
            end
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          rad <= {rad[RAD_W-3:0], 2'b00};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          sqrt_out       <= {{(DATA_WIDTH-ITERS){1'b0}}, q};
          sqrt_valid_out <= 1'b1;
          neg_err        <= neg_q;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_variance_sqrt_unit.sv
// Directed bench for variance_sqrt_unit with a queue-based scoreboard.
module tb_variance_sqrt_unit;
  import layernorm_pkg::*;

  localparam int W = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic        din_valid = 1'b0;
  logic        in_ready;
  logic [W-1:0] sqrt_out;
  logic        sqrt_valid_out;
  logic        neg_err;
  logic        drop_err;
  sqrt_state_e state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W:0] exp_q[$];   // {neg_err, sqrt_out}
  int         lat_q[$];   // cycle in which the result must appear

  variance_sqrt_unit dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .var_plus_eps_in       (din),
    .var_plus_eps_valid_in (din_valid),
    .in_ready              (in_ready),
    .sqrt_out              (sqrt_out),
    .sqrt_valid_out        (sqrt_valid_out),
    .neg_err               (neg_err),
    .drop_err              (drop_err),
    .state_dbg             (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    logic [W:0] e;
    int         l;
    if (rst_n) begin
      if (sqrt_valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("sqrt_out", 32'(sqrt_out), 32'(e[W-1:0]));
          check("neg_err", 32'(neg_err), 32'(e[W]));
          check("latency", 32'(cyc), 32'(l));
        end
      end else if (neg_err) begin
        check("neg_err_without_valid", 32'd1, 32'd0);
      end
    end
  end

  // Driver: call at #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [W-1:0] v, input logic [W-1:0] e, input logic n);
    int waitn = 0;
    while (!in_ready && waitn < 100) begin
      @(posedge clk); #1;
      waitn++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    din       = v;
    din_valid = 1'b1;
    exp_q.push_back({n, e});
    lat_q.push_back(cyc + 24);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waitn = 0;
    while (exp_q.size() != 0 && waitn < 200) begin
      @(posedge clk); #1;
      waitn++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [W-1:0] vec_in  [9];
  logic [W-1:0] vec_exp [9];
  logic         vec_neg [9];

  initial begin
    vec_in[0] = 24'd1048576;  vec_exp[0] = 24'd1048576; vec_neg[0] = 1'b0;
    vec_in[1] = 24'd4194304;  vec_exp[1] = 24'd2097152; vec_neg[1] = 1'b0;
    vec_in[2] = 24'd262144;   vec_exp[2] = 24'd524288;  vec_neg[2] = 1'b0;
    vec_in[3] = 24'd11;       vec_exp[3] = 24'd3396;    vec_neg[3] = 1'b0;
    vec_in[4] = 24'h7FFFFF;   vec_exp[4] = 24'd2965820; vec_neg[4] = 1'b0;
    vec_in[5] = 24'hFFFFFF;   vec_exp[5] = 24'd0;       vec_neg[5] = 1'b1;
    vec_in[6] = 24'd0;        vec_exp[6] = 24'd0;       vec_neg[6] = 1'b0;
    vec_in[7] = 24'h800000;   vec_exp[7] = 24'd0;       vec_neg[7] = 1'b1;
    vec_in[8] = 24'd1;        vec_exp[8] = 24'd1024;    vec_neg[8] = 1'b0;

    // Reset values while held in reset.
    #1;
    check("rst_sqrt_out", 32'(sqrt_out), 32'd0);
    check("rst_valid", 32'(sqrt_valid_out), 32'd0);
    check("rst_neg_err", 32'(neg_err), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors back to back.
    for (int i = 0; i < 9; i++) begin
      send(vec_in[i], vec_exp[i], vec_neg[i]);
    end
    wait_drain();

    // Valid while busy is dropped; the next accept lands at t+24.
    send(24'd1048576, 24'd1048576, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    din = 24'hFFFFFF;
    din_valid = 1'b1;
    @(posedge clk); #1;
    check("drop_err_busy", 32'(drop_err), 32'd1);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    check("drop_err_clear", 32'(drop_err), 32'd0);
    send(24'd262144, 24'd524288, 1'b0);
    wait_drain();

    // Valid during the DONE cycle is dropped.
    send(24'd4194304, 24'd2097152, 1'b0);
    repeat (22) @(posedge clk);
    #1;
    check("state_done", 32'(state_dbg), 32'(DONE));
    check("in_ready_done", 32'(in_ready), 32'd0);
    din = 24'd11;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    check("drop_err_done", 32'(drop_err), 32'd1);
    check("state_after_done", 32'(state_dbg), 32'(IDLE));
    wait_drain();

    // Reset in the middle of the computation aborts it.
    send(24'd1048576, 24'd1048576, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    check("state_calc", 32'(state_dbg), 32'(CALC));
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("abort_sqrt_out", 32'(sqrt_out), 32'd0);
    check("abort_valid", 32'(sqrt_valid_out), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_abort_sqrt_out", 32'(sqrt_out), 32'd0);
    send(24'd1048576, 24'd1048576, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
